// File: rtl/mmc_arm_inserter.sv
// MMC arm inserter: turns a requested inserted-submodule count into per-submodule gate bits,
// slew-limited to one switching event per DWELL_CYC+1 cycles with rotating submodule usage.
module mmc_arm_inserter #(
    parameter int unsigned N_SM      = 8,
    parameter int unsigned LVL_W     = 7,
    parameter int unsigned DWELL_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lvl_valid,
    output logic             lvl_ready,
    input  logic [LVL_W-1:0] lvl_target,
    output logic [N_SM-1:0]  sm_insert,
    output logic [LVL_W-1:0] n_inserted,
    output logic             busy,
    output logic             sat
);

    localparam int unsigned IDX_W = $clog2(N_SM);
    localparam int unsigned DW_W  = (DWELL_CYC > 2) ? $clog2(DWELL_CYC) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [DW_W-1:0]   dwell_cnt, dwell_n;
    logic [IDX_W-1:0]  head, head_n;
    logic [IDX_W-1:0]  tail, tail_n;
    logic [LVL_W-1:0]  target_q, target_n;
    logic [LVL_W-1:0]  cnt_n;
    logic [N_SM-1:0]   sm_n;
    logic              sat_n;
    logic              busy_n;
    logic              switched;

    // Circular pointer advance with wrap at N_SM-1.
    function automatic logic [IDX_W-1:0] adv(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(N_SM - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Next-state: target capture, at most one switching event, dwell timing.
    always_comb begin
        state_n  = state;
        dwell_n  = dwell_cnt;
        head_n   = head;
        tail_n   = tail;
        sm_n     = sm_insert;
        cnt_n    = n_inserted;
        target_n = target_q;
        sat_n    = sat;
        switched = 1'b0;

        if (lvl_valid) begin
            if (lvl_target > LVL_W'(N_SM)) begin
                target_n = LVL_W'(N_SM);
                sat_n    = 1'b1;
            end else begin
                target_n = lvl_target;
                sat_n    = 1'b0;
            end
        end

        unique case (state)
            IDLE: begin
                if (n_inserted < target_q) begin
                    sm_n[head] = 1'b1;
                    head_n     = adv(head);
                    cnt_n      = n_inserted + LVL_W'(1);
                    switched   = 1'b1;
                end else if (n_inserted > target_q) begin
                    // Removing the oldest insertion keeps usage rotating around the arm.
                    sm_n[tail] = 1'b0;
                    tail_n     = adv(tail);
                    cnt_n      = n_inserted - LVL_W'(1);
                    switched   = 1'b1;
                end
            end
            DWELL: begin
                if (dwell_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    dwell_n = dwell_cnt - DW_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (switched && (DWELL_CYC != 0)) begin
            state_n = DWELL;
            dwell_n = DW_W'(DWELL_CYC - 1);
        end

        busy_n = (cnt_n != target_n) || (state_n == DWELL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dwell_cnt  <= '0;
            head       <= '0;
            tail       <= '0;
            target_q   <= '0;
            sm_insert  <= '0;
            n_inserted <= '0;
            sat        <= 1'b0;
            busy       <= 1'b0;
            lvl_ready  <= 1'b0;
        end else begin
            state      <= state_n;
            dwell_cnt  <= dwell_n;
            head       <= head_n;
            tail       <= tail_n;
            target_q   <= target_n;
            sm_insert  <= sm_n;
            n_inserted <= cnt_n;
            sat        <= sat_n;
            busy       <= busy_n;
            lvl_ready  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmc_arm_inserter.sv
// Self-checking bench for mmc_arm_inserter: directed vector table, corner sequences,
// and random targets against a queue-based reference model.
module tb_mmc_arm_inserter;

    localparam int unsigned N_SM      = 8;
    localparam int unsigned LVL_W     = 7;
    localparam int unsigned DWELL_CYC = 2;

    logic             clk;
    logic             rst_n;
    logic             lvl_valid;
    logic             lvl_ready;
    logic [LVL_W-1:0] lvl_target;
    logic [N_SM-1:0]  sm_insert;
    logic [LVL_W-1:0] n_inserted;
    logic             busy;
    logic             sat;

    mmc_arm_inserter #(
        .N_SM      (N_SM),
        .LVL_W     (LVL_W),
        .DWELL_CYC (DWELL_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lvl_valid  (lvl_valid),
        .lvl_ready  (lvl_ready),
        .lvl_target (lvl_target),
        .sm_insert  (sm_insert),
        .n_inserted (n_inserted),
        .busy       (busy),
        .sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO of inserted indices (oldest first), next index to insert,
    // clamped target, and cycles remaining before another event is allowed.
    int mq[$];
    int m_nxt;
    int m_tgt;
    bit m_sat;
    int m_cool;

    logic [N_SM-1:0] prev_sm;
    int tog[N_SM];

    typedef struct {
        bit         v;
        int         t;
        logic [7:0] sm;
        int         n;
        bit         bsy;
        bit         st;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N_SM-1:0] m_mask();
        logic [N_SM-1:0] m = '0;
        foreach (mq[i]) m[mq[i]] = 1'b1;
        return m;
    endfunction

    function automatic bit m_busy();
        return (mq.size() != m_tgt) || (m_cool > 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_nxt  = 0;
        m_tgt  = 0;
        m_sat  = 1'b0;
        m_cool = 0;
    endtask

    task automatic model_edge(input bit v, input int t);
        if (m_cool > 0) begin
            m_cool--;
        end else if (mq.size() < m_tgt) begin
            mq.push_back(m_nxt);
            m_nxt  = (m_nxt + 1) % N_SM;
            m_cool = DWELL_CYC;
        end else if (mq.size() > m_tgt) begin
            void'(mq.pop_front());
            m_cool = DWELL_CYC;
        end
        if (v) begin
            m_tgt = (t > N_SM) ? N_SM : t;
            m_sat = (t > N_SM);
        end
    endtask

    task automatic check_model();
        logic [N_SM-1:0] d;
        d = sm_insert ^ prev_sm;
        chk("model_sm_insert", 32'(sm_insert), 32'(m_mask()));
        chk("model_n_inserted", 32'(n_inserted), 32'(mq.size()));
        chk("model_busy", 32'(busy), 32'(m_busy()));
        chk("model_sat", 32'(sat), 32'(m_sat));
        chk("lvl_ready", 32'(lvl_ready), 32'd1);
        chk("popcount", 32'(n_inserted), 32'($countones(sm_insert)));
        chk("one_bit_per_edge", 32'($countones(d) <= 1), 32'd1);
        for (int b = 0; b < N_SM; b++) tog[b] += int'(d[b]);
        prev_sm = sm_insert;
    endtask

    task automatic step(input bit v, input int t);
        lvl_valid  = v;
        lvl_target = LVL_W'(t);
        @(posedge clk);
        #1;
        model_edge(v, t);
        check_model();
        lvl_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!m_busy()) begin
                done = 1'b1;
                break;
            end
            step(1'b0, 0);
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Asynchronous reset; outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_sm_insert", 32'(sm_insert), 32'd0);
        chk("rst_n_inserted", 32'(n_inserted), 32'd0);
        chk("rst_lvl_ready", 32'(lvl_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        prev_sm = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Target 3 from reset, then target 1 once settled.
        tbl[0]  = '{1'b1, 3, 8'h00, 0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 0, 8'h01, 1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 0, 8'h01, 1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 0, 8'h01, 1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 0, 8'h03, 2, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 0, 8'h03, 2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 0, 8'h03, 2, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 0, 8'h07, 3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 0, 8'h07, 3, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 0, 8'h07, 3, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1, 8'h07, 3, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 0, 8'h06, 2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 0, 8'h06, 2, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 0, 8'h06, 2, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 0, 8'h04, 1, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 0, 8'h04, 1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 0, 8'h04, 1, 1'b0, 1'b0};

        rst_n      = 1'b0;
        lvl_valid  = 1'b0;
        lvl_target = '0;
        prev_sm    = '0;
        model_reset();
        #3;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].t);
            chk($sformatf("tbl%0d_sm", i), 32'(sm_insert), 32'(tbl[i].sm));
            chk($sformatf("tbl%0d_n", i), 32'(n_inserted), 32'(tbl[i].n));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_sat", i), 32'(sat), 32'(tbl[i].st));
        end

        // Rotation: full/empty three times, every bit toggles six times.
        do_reset();
        for (int b = 0; b < N_SM; b++) tog[b] = 0;
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 8);
            wait_idle("settle_full");
            chk("full_sm", 32'(sm_insert), 32'hFF);
            step(1'b1, 0);
            wait_idle("settle_empty");
            chk("empty_sm", 32'(sm_insert), 32'h00);
        end
        for (int b = 0; b < N_SM; b++) chk($sformatf("toggles_bit%0d", b), 32'(tog[b]), 32'd6);

        // Saturation clamp.
        step(1'b1, 100);
        chk("sat_set", 32'(sat), 32'd1);
        wait_idle("settle_sat");
        chk("sat_sm", 32'(sm_insert), 32'hFF);
        chk("sat_n", 32'(n_inserted), 32'd8);
        step(1'b1, 5);
        chk("sat_clear", 32'(sat), 32'd0);
        wait_idle("settle_5");
        chk("after_sat_n", 32'(n_inserted), 32'd5);

        // Target change during the first dwell.
        do_reset();
        step(1'b1, 4);
        step(1'b0, 0);
        step(1'b1, 2);
        wait_idle("settle_dwell_change");
        chk("dwell_change_n", 32'(n_inserted), 32'd2);
        chk("dwell_change_sm", 32'(sm_insert), 32'h03);

        // Reset mid-slew at count 3, then a fresh insert from bit 0.
        do_reset();
        step(1'b1, 5);
        for (int k = 0; k < 7; k++) step(1'b0, 0);
        chk("midslew_n", 32'(n_inserted), 32'd3);
        chk("midslew_busy", 32'(busy), 32'd1);
        do_reset();
        step(1'b1, 1);
        step(1'b0, 0);
        chk("post_reset_sm", 32'(sm_insert), 32'h01);

        // Random targets against the model.
        for (int k = 0; k < 3000; k++) begin
            bit v;
            int t;
            v = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, N_SM));
            step(v, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
